operand_seq_ctrl: RTL and testbench

- Controller for the single-port operand matrix register file (1-cycle registered read, synchronous write, shared address port).
- Arbitrates the memory port between host writes (matrix load) and a sequenced read stream that feeds the MAC datapath.
- Streams a dim x dim sub-matrix in row-major or transposed (column-major) order over a valid/ready interface with backpressure.

---
 rtl/operand_pkg.sv | 29 ++
 rtl/operand_skid_fifo.sv | 62 ++++++
 rtl/operand_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_operand_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared types and constants for the operand matrix sequencer.
// addr_calc maps (outer, inner, transpose) to a row-major storage address.
package operand_pkg;

  localparam int MAX_DIM    = 4;
  localparam int ADDR_WIDTH = $clog2(MAX_DIM * MAX_DIM);
  localparam int DIM_WIDTH  = $clog2(MAX_DIM + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Storage stride is always MAX_DIM, independent of the active sub-matrix size.
  function automatic logic [ADDR_WIDTH-1:0] addr_calc(
    input logic [DIM_WIDTH-1:0] o,
    input logic [DIM_WIDTH-1:0] i,
    input logic                 transpose
  );
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] col;
    row = transpose ? ADDR_WIDTH'(i) : ADDR_WIDTH'(o);
    col = transpose ? ADDR_WIDTH'(o) : ADDR_WIDTH'(i);
    return (row * ADDR_WIDTH'(MAX_DIM)) + col;
  endfunction

endpackage

// File: rtl/operand_skid_fifo.sv
// Two-entry FIFO holding {data, eol, last} between the register file read
// port and the stream consumer; simultaneous push and pop are both honoured.
module operand_skid_fifo #(
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full buffer is only accepted when a pop frees a slot.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/operand_seq_ctrl.sv
// Operand register file controller: arbitrates host writes against a
// sequenced dim x dim read stream (row-major or transposed) with backpressure.
module operand_seq_ctrl
  import operand_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DIM_WIDTH-1:0]  dim_i,
  input  logic                  transpose_i,
  input  logic                  host_wr_valid_i,
  output logic                  host_wr_ready_o,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wr_data_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_eol_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  localparam int TAG_WIDTH = DATA_WIDTH + 2;

  state_e               state_q, state_d;
  logic [DIM_WIDTH-1:0] dim_q, dim_d;
  logic [DIM_WIDTH-1:0] o_q, o_d;
  logic [DIM_WIDTH-1:0] i_q, i_d;
  logic                 tr_q, tr_d;
  logic                 inflight_q, inflight_d;
  logic                 tag_eol_q, tag_eol_d;
  logic                 tag_last_q, tag_last_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 pop;
  logic                 host_hs;
  logic                 issue_eol;
  logic                 issue_last;
  logic [1:0]           fifo_count;
  logic [2:0]           occupancy;
  logic [TAG_WIDTH-1:0] fifo_out;

  assign out_valid_o = (fifo_count != 2'd0);
  assign pop         = out_valid_o && out_ready_i;
  assign {out_data_o, out_eol_o, out_last_o} = fifo_out;

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign cfg_err_o = cfg_err_q;

  // Start takes the port over a same-cycle host write; busy cycles stall the host.
  assign host_wr_ready_o = rst_ni && (state_q == IDLE) && !start_i;
  assign host_hs         = host_wr_valid_i && host_wr_ready_o;
  assign mem_we_o        = host_hs;
  assign mem_addr_o      = host_hs ? host_wr_addr_i : addr_calc(o_q, i_q, tr_q);
  assign mem_wdata_o     = host_hs ? host_wr_data_i : '0;

  // Counting the in-flight read as occupied keeps the 2-entry buffer from overflowing.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_eol  = (i_q == dim_q - DIM_WIDTH'(1));
  assign issue_last = issue_eol && (o_q == dim_q - DIM_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    dim_d      = dim_q;
    tr_d       = tr_q;
    o_d        = o_q;
    i_d        = i_q;
    inflight_d = 1'b0;
    tag_eol_d  = tag_eol_q;
    tag_last_d = tag_last_q;
    cfg_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((dim_i != '0) && (dim_i <= DIM_WIDTH'(MAX_DIM))) begin
            dim_d   = dim_i;
            tr_d    = transpose_i;
            o_d     = '0;
            i_d     = '0;
            state_d = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (occupancy < 3'd2) begin
          inflight_d = 1'b1;
          tag_eol_d  = issue_eol;
          tag_last_d = issue_last;
          if (issue_eol) begin
            i_d = '0;
            if (issue_last) begin
              o_d     = '0;
              state_d = DRAIN;
            end else begin
              o_d = o_q + DIM_WIDTH'(1);
            end
          end else begin
            i_d = i_q + DIM_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifo_count == 2'd0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      dim_q      <= '0;
      tr_q       <= 1'b0;
      o_q        <= '0;
      i_q        <= '0;
      inflight_q <= 1'b0;
      tag_eol_q  <= 1'b0;
      tag_last_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dim_q      <= dim_d;
      tr_q       <= tr_d;
      o_q        <= o_d;
      i_q        <= i_d;
      inflight_q <= inflight_d;
      tag_eol_q  <= tag_eol_d;
      tag_last_q <= tag_last_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Read data arrives one cycle after issue and is tagged from the issue-time indices.
  operand_skid_fifo #(
    .WIDTH(TAG_WIDTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (inflight_q),
    .pop_i  (pop),
    .data_i ({mem_rdata_i, tag_eol_q, tag_last_q}),
    .data_o (fifo_out),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Self-checking bench for operand_seq_ctrl: a register file model plus a
// reference stream derived from the matrix contents the bench itself wrote.
module tb_operand_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  dim_i = '0;
  logic        transpose_i = 1'b0;
  logic        host_wr_valid_i = 1'b0;
  logic        host_wr_ready_o;
  logic [3:0]  host_wr_addr_i = '0;
  logic [31:0] host_wr_data_i = '0;
  logic [3:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic        out_eol_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;
  logic        cfg_err_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] refMem [16];
  logic [31:0] rf [16];

  operand_seq_ctrl #(.DATA_WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .dim_i          (dim_i),
    .transpose_i    (transpose_i),
    .host_wr_valid_i(host_wr_valid_i),
    .host_wr_ready_o(host_wr_ready_o),
    .host_wr_addr_i (host_wr_addr_i),
    .host_wr_data_i (host_wr_data_i),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_we_o       (mem_we_o),
    .mem_rdata_i    (mem_rdata_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_eol_o      (out_eol_o),
    .out_last_o     (out_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .cfg_err_o      (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-port register file: synchronous write, registered read.
  always @(posedge clk_i) begin
    if (mem_we_o) rf[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= rf[mem_addr_o];
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic hostWrite(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    host_wr_valid_i = 1'b1;
    host_wr_addr_i  = addr;
    host_wr_data_i  = data;
    #1;
    checkOutput("wr_ready", 32'(host_wr_ready_o), 32'd1);
    checkOutput("wr_we", 32'(mem_we_o), 32'd1);
    checkOutput("wr_addr", 32'(mem_addr_o), 32'(addr));
    checkOutput("wr_data", mem_wdata_o, data);
    refMem[addr] = data;
    @(negedge clk_i);
    host_wr_valid_i = 1'b0;
  endtask

  task automatic badStart(input logic [2:0] dim);
    @(negedge clk_i);
    start_i = 1'b1;
    dim_i   = dim;
    host_wr_valid_i = 1'b1;
    #1;
    checkOutput("bad_start_ready", 32'(host_wr_ready_o), 32'd0);
    checkOutput("bad_start_we", 32'(mem_we_o), 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    host_wr_valid_i = 1'b0;
    #1;
    checkOutput("cfg_err_pulse", 32'(cfg_err_o), 32'd1);
    checkOutput("cfg_err_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    #1;
    checkOutput("cfg_err_clear", 32'(cfg_err_o), 32'd0);
    checkOutput("cfg_err_busy2", 32'(busy_o), 32'd0);
    checkOutput("cfg_err_valid", 32'(out_valid_o), 32'd0);
  endtask

  // Runs one stream. readyPct sets consumer readiness, holdWrite keeps a host
  // write pending for the whole stream, abortAfter>0 pulls reset after that many elements.
  task automatic applyStimulus(input int dim, input bit tr, input int readyPct, input bit holdWrite,
                               input int abortAfter, input logic [3:0] wrAddr, input logic [31:0] wrData);
    logic [31:0] expData[$];
    bit          expEol[$];
    bit          expLast[$];
    int          n;
    int          k;
    int          firstValid;
    int          lastHs;
    bit          sawDone;
    bit          aborted;
    bit          prevStall;
    n = dim * dim;
    k = 0;
    firstValid = -1;
    lastHs = -1;
    sawDone = 1'b0;
    aborted = 1'b0;
    prevStall = 1'b0;
    for (int e = 0; e < n; e++) begin
      int o;
      int i;
      o = e / dim;
      i = e % dim;
      expData.push_back(refMem[tr ? (i * 4 + o) : (o * 4 + i)]);
      expEol.push_back(i == dim - 1);
      expLast.push_back(e == n - 1);
    end

    @(negedge clk_i);
    start_i         = 1'b1;
    dim_i           = 3'(dim);
    transpose_i     = tr;
    out_ready_i     = 1'b0;
    host_wr_valid_i = holdWrite;
    host_wr_addr_i  = wrAddr;
    host_wr_data_i  = wrData;
    #1;
    if (holdWrite) begin
      checkOutput("start_wins_ready", 32'(host_wr_ready_o), 32'd0);
      checkOutput("start_wins_we", 32'(mem_we_o), 32'd0);
    end

    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk_i);
      start_i     = 1'b0;
      dim_i       = 3'($urandom_range(7));
      transpose_i = 1'($urandom_range(1));
      out_ready_i = ($urandom_range(99) < readyPct);
      #1;
      if (holdWrite) begin
        checkOutput("busy_wr_ready", 32'(host_wr_ready_o), 32'd0);
        checkOutput("busy_wr_we", 32'(mem_we_o), 32'd0);
      end
      if (prevStall) checkOutput("stall_valid_held", 32'(out_valid_o), 32'd1);
      prevStall = out_valid_o && !out_ready_i;
      if (out_valid_o && firstValid < 0) firstValid = cyc;
      if (out_valid_o && out_ready_i) begin
        if (k < n) begin
          checkOutput("elem_data", out_data_o, expData[k]);
          checkOutput("elem_eol", 32'(out_eol_o), 32'(expEol[k]));
          checkOutput("elem_last", 32'(out_last_o), 32'(expLast[k]));
          if (readyPct >= 100) checkOutput("elem_cycle", 32'(cyc), 32'(firstValid + k));
        end else begin
          checkOutput("extra_element", 32'(out_valid_o), 32'd0);
        end
        lastHs = cyc;
        k++;
        if (abortAfter > 0 && k == abortAfter) begin
          @(posedge clk_i);
          #2;
          rst_ni = 1'b0;
          #1;
          checkOutput("abort_valid", 32'(out_valid_o), 32'd0);
          checkOutput("abort_busy", 32'(busy_o), 32'd0);
          checkOutput("abort_done", 32'(done_o), 32'd0);
          aborted = 1'b1;
          break;
        end
      end
      if (done_o) begin
        sawDone = 1'b1;
        checkOutput("done_count", 32'(k), 32'(n));
        checkOutput("done_delay", 32'(cyc), 32'(lastHs + 2));
        break;
      end
    end

    if (!aborted) begin
      checkOutput("done_seen", 32'(sawDone), 32'd1);
      if (readyPct >= 100) checkOutput("first_valid_latency", 32'(firstValid), 32'd3);
      @(negedge clk_i);
      out_ready_i = 1'b1;
      #1;
      checkOutput("done_one_cycle", 32'(done_o), 32'd0);
      checkOutput("idle_busy", 32'(busy_o), 32'd0);
      if (holdWrite) begin
        checkOutput("deferred_wr_ready", 32'(host_wr_ready_o), 32'd1);
        checkOutput("deferred_wr_we", 32'(mem_we_o), 32'd1);
        checkOutput("deferred_wr_addr", 32'(mem_addr_o), 32'(wrAddr));
        refMem[wrAddr] = wrData;
        @(negedge clk_i);
        host_wr_valid_i = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset_valid", 32'(out_valid_o), 32'd0);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_cfg_err", 32'(cfg_err_o), 32'd0);
    checkOutput("reset_we", 32'(mem_we_o), 32'd0);
    checkOutput("reset_wr_ready", 32'(host_wr_ready_o), 32'd0);
    checkOutput("reset_data", out_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Matrix load then the two directed streams.
    for (int a = 0; a < 16; a++) hostWrite(4'(a), 32'h100 + 32'(a));
    applyStimulus(4, 1'b0, 100, 1'b0, 0, 4'd0, 32'd0);
    applyStimulus(3, 1'b1, 100, 1'b0, 0, 4'd0, 32'd0);

    // Backpressure and randomized contents/configuration.
    applyStimulus(4, 1'b0, 50, 1'b0, 0, 4'd0, 32'd0);
    for (int r = 0; r < 5; r++) begin
      repeat (4) hostWrite(4'($urandom_range(15)), $urandom);
      applyStimulus(int'($urandom_range(1, 4)), 1'($urandom_range(1)), 50, 1'b0, 0, 4'd0, 32'd0);
    end

    badStart(3'd0);
    badStart(3'd5);
    badStart(3'd7);

    // Pending host write across a stream, then a read that covers the written word.
    applyStimulus(3, 1'b0, 100, 1'b1, 0, 4'd5, 32'hCAFE_0005);
    applyStimulus(3, 1'b0, 100, 1'b0, 0, 4'd0, 32'd0);

    // Reset after five elements, then a fresh stream from element 0.
    applyStimulus(4, 1'b0, 100, 1'b0, 5, 4'd0, 32'd0);
    repeat (2) begin
      @(negedge clk_i);
      #1;
      checkOutput("in_reset_done", 32'(done_o), 32'd0);
      checkOutput("in_reset_valid", 32'(out_valid_o), 32'd0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(4, 1'b1, 100, 1'b0, 0, 4'd0, 32'd0);
    applyStimulus(4, 1'b0, 70, 1'b0, 0, 4'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
